// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Shared constants and types for the traffic-light input conditioner:
//   MINUTES_PER_DAY / TOD_W / TOD_LAST : time-of-day range and width
//   mode_e                             : operating mode encodings
//   deb_state_e                        : per-sensor debounce FSM states
//   in_window()                        : half-open [lo,hi) minute window test
// ---------------------------------------------------------------------------
package tlc_pkg;

    localparam int MINUTES_PER_DAY = 1440;
    localparam int TOD_W           = 11;
    localparam logic [TOD_W-1:0] TOD_LAST = TOD_W'(MINUTES_PER_DAY - 1);

    typedef enum logic [1:0] {
        MODE_AUTO       = 2'b00,
        MODE_FORCE_OFF  = 2'b01,
        MODE_FORCE_PEAK = 2'b10,
        MODE_AUTO_ALT   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMING    = 2'd1,
        S_ACTIVE    = 2'd2,
        S_RELEASING = 2'd3
    } deb_state_e;

    function automatic logic in_window(input logic [TOD_W-1:0] t,
                                       input int lo, input int hi);
        return (int'(t) >= lo) && (int'(t) < hi);
    endfunction

endpackage

// File: rtl/tlc_input_cond_if.sv
// ---------------------------------------------------------------------------
// tlc_input_cond_if
// Bus between the input conditioner and its environment.
//   raw_s1/raw_s2 : unsynchronised loop detectors (to conditioner)
//   mode          : 00/11 auto, 01 force off-peak, 10 force peak
//   tod_load/tod_value : time-of-day load request
//   sensor1/sensor2, peak, tod, minute_tick, load_err : conditioned outputs
// master = stimulus/environment side, slave = conditioner side.
// ---------------------------------------------------------------------------
interface tlc_input_cond_if;
    import tlc_pkg::*;

    logic             raw_s1;
    logic             raw_s2;
    logic [1:0]       mode;
    logic             tod_load;
    logic [TOD_W-1:0] tod_value;
    logic             sensor1;
    logic             sensor2;
    logic             peak;
    logic [TOD_W-1:0] tod;
    logic             minute_tick;
    logic             load_err;

    modport master (
        output raw_s1, raw_s2, mode, tod_load, tod_value,
        input  sensor1, sensor2, peak, tod, minute_tick, load_err
    );

    modport slave (
        input  raw_s1, raw_s2, mode, tod_load, tod_value,
        output sensor1, sensor2, peak, tod, minute_tick, load_err
    );

endinterface

// File: rtl/tlc_sensor_debounce.sv
// ---------------------------------------------------------------------------
// tlc_sensor_debounce
// One vehicle-loop channel: 2-flop synchroniser, debounce FSM with a shared
// run counter, and a registered presence output.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_raw        : raw detector input (asynchronous)
//   o_sensor     : debounced presence, high while ACTIVE/RELEASING
// ---------------------------------------------------------------------------
module tlc_sensor_debounce
    import tlc_pkg::*;
#(
    parameter int DEB_ON  = 4,
    parameter int DEB_OFF = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_sensor
);

    localparam int CNT_MAX = (DEB_ON > DEB_OFF) ? DEB_ON : DEB_OFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(DEB_ON);
    localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(DEB_OFF);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    // A limit of 1 means the first qualifying sample completes the run.
    localparam bit ON_IMMED  = (DEB_ON  <= 1);
    localparam bit OFF_IMMED = (DEB_OFF <= 1);

    logic [1:0]       r_sync;
    logic             w_in;
    deb_state_e       r_state;
    deb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_sensor;

    assign w_in = r_sync[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sensor <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            // Output flop lags the state by one edge; this places the
            // rise/fall at 2+DEB_ON / 2+DEB_OFF edges after the raw change.
            r_sensor <= (r_state == S_ACTIVE) || (r_state == S_RELEASING);
        end
    end

    // Counter holds the length of the current qualifying run; it is only
    // meaningful in ARMING/RELEASING and kept at zero elsewhere.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = r_cnt + ONE;
        case (r_state)
            S_IDLE: begin
                if (w_in) begin
                    if (ON_IMMED) begin
                        w_state_nxt = S_ACTIVE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_ARMING;
                        w_cnt_nxt   = ONE;
                    end
                end
            end
            S_ARMING: begin
                if (!w_in) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc >= ON_LIM) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_ACTIVE: begin
                if (!w_in) begin
                    if (OFF_IMMED) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_RELEASING;
                        w_cnt_nxt   = ONE;
                    end
                end
            end
            S_RELEASING: begin
                if (w_in) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc >= OFF_LIM) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_sensor = r_sensor;

endmodule

// File: rtl/tlc_input_cond.sv
// ---------------------------------------------------------------------------
// tlc_input_cond
// Input conditioning for a traffic-light controller: debounces two vehicle
// loops, keeps a minute-of-day clock with load/validation, and derives a
// registered peak-hour flag.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : tlc_input_cond_if.slave (raw inputs, mode, TOD load in;
//                sensors, peak, tod, minute_tick, load_err out)
// ---------------------------------------------------------------------------
module tlc_input_cond
    import tlc_pkg::*;
#(
    parameter int TICKS_PER_MIN = 60,
    parameter int DEB_ON        = 4,
    parameter int DEB_OFF       = 8,
    parameter int AM_START      = 420,
    parameter int AM_END        = 600,
    parameter int PM_START      = 990,
    parameter int PM_END        = 1170
) (
    input  logic              clk,
    input  logic              reset,
    tlc_input_cond_if.slave   bus
);

    localparam int NUM_SENSORS = 2;
    localparam int PRE_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MIN - 1);

    logic [NUM_SENSORS-1:0] w_raw;
    logic [NUM_SENSORS-1:0] w_sensor;

    logic [PRE_W-1:0] r_presc;
    logic [TOD_W-1:0] r_tod;
    logic             r_tick;
    logic             r_err;
    logic             r_peak;
    logic             w_wrap;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_peak;

    // ---------------- sensor channels ----------------
    assign w_raw = {bus.raw_s2, bus.raw_s1};

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_deb
        tlc_sensor_debounce #(
            .DEB_ON  (DEB_ON),
            .DEB_OFF (DEB_OFF)
        ) u_deb (
            .i_clk    (clk),
            .i_rst    (reset),
            .i_raw    (w_raw[g]),
            .o_sensor (w_sensor[g])
        );
    end

    assign bus.sensor1 = w_sensor[0];
    assign bus.sensor2 = w_sensor[1];

    // ---------------- time of day ----------------
    assign w_wrap     = (r_presc == PRE_LAST);
    assign w_load_ok  = bus.tod_load && (bus.tod_value <= TOD_LAST);
    assign w_load_bad = bus.tod_load && (bus.tod_value >  TOD_LAST);

    // A valid load restarts the minute and takes priority over a coincident
    // wrap (no increment, no tick). A rejected load leaves counting alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_tod   <= '0;
            r_tick  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_err  <= w_load_bad;
            if (w_load_ok) begin
                r_tod   <= bus.tod_value;
                r_presc <= '0;
            end else if (w_wrap) begin
                r_presc <= '0;
                r_tod   <= (r_tod == TOD_LAST) ? '0 : r_tod + TOD_W'(1);
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    // ---------------- peak flag ----------------
    always_comb begin
        w_peak = 1'b0;
        case (mode_e'(bus.mode))
            MODE_FORCE_OFF:  w_peak = 1'b0;
            MODE_FORCE_PEAK: w_peak = 1'b1;
            default:         w_peak = in_window(r_tod, AM_START, AM_END) ||
                                      in_window(r_tod, PM_START, PM_END);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_peak <= 1'b0;
        end else begin
            r_peak <= w_peak;
        end
    end

    assign bus.tod         = r_tod;
    assign bus.minute_tick = r_tick;
    assign bus.load_err    = r_err;
    assign bus.peak        = r_peak;

endmodule

// File: tb/tb_tlc_input_cond.sv
// ---------------------------------------------------------------------------
// tb_tlc_input_cond
// Directed scenarios plus randomized traffic against a behavioural model of
// the input conditioner (run-length debounce, absolute-minute clock).
// ---------------------------------------------------------------------------
module tb_tlc_input_cond;

    localparam int TPM      = 60;
    localparam int DEB_ON   = 4;
    localparam int DEB_OFF  = 8;
    localparam int AM_START = 420;
    localparam int AM_END   = 600;
    localparam int PM_START = 990;
    localparam int PM_END   = 1170;

    logic clk;
    logic reset;

    tlc_input_cond_if ifc ();

    tlc_input_cond #(
        .TICKS_PER_MIN (TPM),
        .DEB_ON        (DEB_ON),
        .DEB_OFF       (DEB_OFF),
        .AM_START      (AM_START),
        .AM_END        (AM_END),
        .PM_START      (PM_START),
        .PM_END        (PM_END)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_err;

    // ---------------- reference model state ----------------
    bit m_s0 [2];
    bit m_s1 [2];
    bit m_ds [2];      // debounced presence decided so far
    int ones_run [2];
    int zeros_run [2];
    int m_base;        // minute value at last valid load/reset
    int m_cyc;         // edges since then
    bit exp_sen [2];
    int exp_tod;
    bit exp_tick;
    bit exp_err;
    bit exp_peak;

    logic [10:0] bnd [10] = '{11'd419, 11'd420, 11'd599, 11'd600, 11'd989,
                              11'd990, 11'd1169, 11'd1170, 11'd1439, 11'd1440};

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit peak_ref(input int t, input logic [1:0] m);
        if (m == 2'b01) return 1'b0;
        if (m == 2'b10) return 1'b1;
        return ((t >= AM_START) && (t < AM_END)) || ((t >= PM_START) && (t < PM_END));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s0[i] = 0; m_s1[i] = 0; m_ds[i] = 0;
            ones_run[i] = 0; zeros_run[i] = 0; exp_sen[i] = 0;
        end
        m_base = 0; m_cyc = 0; exp_tod = 0;
        exp_tick = 0; exp_err = 0; exp_peak = 0;
    endtask

    // One rising edge as seen by the model, using the inputs present at it.
    task automatic model_edge();
        bit raw [2];
        int t_old;
        raw[0] = ifc.raw_s1;
        raw[1] = ifc.raw_s2;
        for (int i = 0; i < 2; i++) begin
            if (m_s1[i]) begin ones_run[i]++; zeros_run[i] = 0; end
            else         begin zeros_run[i]++; ones_run[i] = 0; end
            exp_sen[i] = m_ds[i];
            if (!m_ds[i] && ones_run[i] >= DEB_ON)  m_ds[i] = 1;
            else if (m_ds[i] && zeros_run[i] >= DEB_OFF) m_ds[i] = 0;
            m_s1[i] = m_s0[i];
            m_s0[i] = raw[i];
        end
        t_old    = (m_base + m_cyc / TPM) % 1440;
        exp_peak = peak_ref(t_old, ifc.mode);
        exp_err  = ifc.tod_load && (int'(ifc.tod_value) > 1439);
        if (ifc.tod_load && int'(ifc.tod_value) <= 1439) begin
            m_base   = int'(ifc.tod_value);
            m_cyc    = 0;
            exp_tick = 0;
        end else begin
            m_cyc++;
            exp_tick = (m_cyc % TPM) == 0;
        end
        exp_tod = (m_base + m_cyc / TPM) % 1440;
    endtask

    task automatic compare_all();
        chk("sensor1",     int'(ifc.sensor1),     int'(exp_sen[0]));
        chk("sensor2",     int'(ifc.sensor2),     int'(exp_sen[1]));
        chk("tod",         int'(ifc.tod),         exp_tod);
        chk("minute_tick", int'(ifc.minute_tick), int'(exp_tick));
        chk("load_err",    int'(ifc.load_err),    int'(exp_err));
        chk("peak",        int'(ifc.peak),        int'(exp_peak));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s1"},   int'(ifc.sensor1), 0);
        chk({tag, "_s2"},   int'(ifc.sensor2), 0);
        chk({tag, "_tod"},  int'(ifc.tod), 0);
        chk({tag, "_tick"}, int'(ifc.minute_tick), 0);
        chk({tag, "_err"},  int'(ifc.load_err), 0);
        chk({tag, "_peak"}, int'(ifc.peak), 0);
    endtask

    task automatic load(input int v);
        ifc.tod_load  = 1'b1;
        ifc.tod_value = 11'(v);
        step();
        ifc.tod_load  = 1'b0;
    endtask

    // After the edge that first samples raw_s1 high/low, count edges until
    // sensor1 reaches the target level.
    task automatic measure_s1(input bit lvl, input string tag, input int expect_n);
        int n;
        ifc.raw_s1 = lvl;
        step();
        n = 0;
        while (ifc.sensor1 !== lvl && n < 40) begin
            step();
            n++;
        end
        chk(tag, n, expect_n);
    endtask

    initial begin
        int n;
        int seen;
        int r;
        n_vec = 0;
        n_err = 0;
        ifc.raw_s1 = 0; ifc.raw_s2 = 0; ifc.mode = 2'b00;
        ifc.tod_load = 0; ifc.tod_value = '0;
        reset = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // Assert latency and no crosstalk to sensor2
        measure_s1(1'b1, "s1_rise_latency", 2 + DEB_ON);
        repeat (14) step();
        chk("s2_idle", int'(ifc.sensor2), 0);

        // Release glitch of 5 low cycles is absorbed
        ifc.raw_s1 = 0;
        repeat (5) step();
        ifc.raw_s1 = 1;
        seen = 1;
        repeat (15) begin
            step();
            if (ifc.sensor1 !== 1'b1) seen = 0;
        end
        chk("s1_hold_thru_glitch", seen, 1);

        // Full release latency
        measure_s1(1'b0, "s1_fall_latency", 2 + DEB_OFF);
        repeat (4) step();

        // Short assert glitch never reaches the output
        ifc.raw_s1 = 1;
        repeat (3) step();
        ifc.raw_s1 = 0;
        seen = 0;
        repeat (15) begin
            step();
            if (ifc.sensor1 === 1'b1) seen = 1;
        end
        chk("s1_glitch_blocked", seen, 0);

        // End-of-day wrap after load of 1439
        load(1439);
        seen = 0;
        repeat (TPM) begin
            step();
            if (ifc.minute_tick === 1'b1) seen++;
        end
        chk("wrap_tick_count", seen, 1);
        chk("wrap_tod", int'(ifc.tod), 0);
        load(1500);
        chk("bad_load_err", int'(ifc.load_err), 1);
        chk("bad_load_tod", int'(ifc.tod), 0);
        step();
        chk("err_one_cycle", int'(ifc.load_err), 0);

        // Load landing on the prescaler wrap edge wins
        load(100);
        repeat (TPM - 1) step();
        load(200);
        chk("load_wrap_tick", int'(ifc.minute_tick), 0);
        chk("load_wrap_tod", int'(ifc.tod), 200);

        // Peak window boundaries and mode overrides
        ifc.mode = 2'b00;
        load(419);
        step();
        chk("peak_419", int'(ifc.peak), 0);
        n = 0;
        while (ifc.minute_tick !== 1'b1 && n < TPM + 5) begin
            step();
            n++;
        end
        chk("tick_to_420", int'(ifc.tod), 420);
        step();
        chk("peak_420", int'(ifc.peak), 1);
        load(600);
        step();
        chk("peak_600", int'(ifc.peak), 0);
        load(990);
        step();
        chk("peak_990", int'(ifc.peak), 1);
        load(1170);
        step();
        chk("peak_1170", int'(ifc.peak), 0);
        ifc.mode = 2'b10;
        step();
        chk("peak_forced_on", int'(ifc.peak), 1);
        load(450);
        ifc.mode = 2'b01;
        step();
        step();
        chk("peak_forced_off", int'(ifc.peak), 0);
        ifc.mode = 2'b10;
        step();

        // Reset mid-arming and mid-minute
        ifc.raw_s1 = 1;
        repeat (3) step();
        #2 reset = 1'b1;
        model_reset();
        #1 check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        measure_s1(1'b1, "s1_latency_after_reset", 2 + DEB_ON);
        ifc.mode = 2'b00;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) ifc.raw_s1 = ~ifc.raw_s1;
            if ($urandom_range(0, 5) == 0) ifc.raw_s2 = ~ifc.raw_s2;
            if ($urandom_range(0, 99) == 0) ifc.mode = 2'($urandom_range(0, 3));
            ifc.tod_load = 1'b0;
            r = $urandom_range(0, 63);
            if (r == 0) begin
                ifc.tod_load  = 1'b1;
                ifc.tod_value = 11'($urandom_range(0, 2047));
            end else if (r == 1) begin
                ifc.tod_load  = 1'b1;
                ifc.tod_value = bnd[$urandom_range(0, 9)];
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tlc_input_cond.md
TLC_INPUT_COND -- requirements
Module: tlc_input_cond

Interface
REQ-001 Param TICKS_PER_MIN, default 60, clk cycles per simulated minute.
REQ-002 Param DEB_ON, default 4, consecutive synced-high samples to assert a sensor.
REQ-003 Param DEB_OFF, default 8, consecutive synced-low samples to deassert a sensor.
REQ-004 Params AM_START/AM_END/PM_START/PM_END, defaults 420/600/990/1170, peak windows in minutes, half-open [start,end).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 raw_s1, raw_s2  in  1 each  unsynchronised vehicle loop detectors.
REQ-008 mode  in  2  00/11 auto, 01 force off-peak, 10 force peak.
REQ-009 tod_load  in  1  load time-of-day this cycle.
REQ-010 tod_value  in  11  minute value to load.
REQ-011 sensor1, sensor2  out  1 each  debounced presence, registered, feeds controller.
REQ-012 peak  out  1  registered peak flag, feeds controller.
REQ-013 tod  out  11  current minute of day, 0..1439.
REQ-014 minute_tick  out  1  one-cycle pulse on minute advance.
REQ-015 load_err  out  1  one-cycle pulse on rejected load.

Function
REQ-016 Each raw_sN passes a 2-flop synchroniser before any use.
REQ-017 Per-sensor FSM states: IDLE, ARMING, ACTIVE, RELEASING; sensorN = 1 in ACTIVE and RELEASING only.
REQ-018 IDLE -> ARMING on synced 1 (count=1); ARMING -> IDLE on any synced 0 (count cleared); ARMING -> ACTIVE when count reaches DEB_ON.
REQ-019 ACTIVE -> RELEASING on synced 0 (count=1); RELEASING -> ACTIVE on any synced 1; RELEASING -> IDLE when count reaches DEB_OFF.
REQ-020 Latency: raw held high -> sensorN rises at rising edge 2+DEB_ON after the first edge sampling raw high; fall likewise 2+DEB_OFF.
REQ-021 Glitches shorter than DEB_ON (assert) or DEB_OFF (release) cycles produce no output change.
REQ-022 Prescaler counts 0..TICKS_PER_MIN-1; at wrap, minute_tick pulses and tod increments; tod 1439 wraps to 0.
REQ-023 tod_load with tod_value <= 1439: tod <= tod_value, prescaler <= 0, minute_tick suppressed that cycle.
REQ-024 tod_load with tod_value > 1439: tod and prescaler unchanged (normal counting continues), load_err pulses one cycle.
REQ-025 Load coincident with prescaler wrap: valid load wins; no increment, no tick.
REQ-026 peak registered one cycle after tod/mode change: auto -> tod in either window; 01 -> 0; 10 -> 1.
REQ-027 Window bounds: tod==AM_START gives peak, tod==AM_END does not (same for PM).
REQ-028 Counters saturate-free by construction: debounce count width ceil(log2(max(DEB_ON,DEB_OFF)+1)).

Reset
REQ-029 On reset high, immediately: sync flops 0, both FSMs IDLE, counts 0, sensor1=sensor2=0, prescaler 0, tod 0, peak 0, minute_tick 0, load_err 0.
REQ-030 Reset mid-debounce or mid-minute discards partial progress; operation resumes from reset values on first edge after release.

Structure
REQ-031 Package tlc_pkg holds MINUTES_PER_DAY=1440, TOD_W=11, mode encodings, sensor FSM state enum.
REQ-032 Sub-module tlc_sensor_debounce (synchroniser + FSM + counter) instantiated twice; TOD/peak logic in top.

Verification
REQ-033 raw_s1 high 20 cycles (DEB_ON=4) -> sensor1 rises exactly 6 edges after first high sample; sensor2 stays 0.
REQ-034 raw_s1 pulses high 3 cycles then low -> sensor1 never asserts; FSM returns IDLE.
REQ-035 sensor1 active, raw_s1 low 5 cycles then high (DEB_OFF=8) -> sensor1 stays 1; low 8+ cycles -> falls at edge 10.
REQ-036 load tod_value=1439, run 60 cycles -> minute_tick once, tod=0; load 1500 -> load_err pulse, tod unchanged.
REQ-037 load 419, mode=00 -> peak 0; after next tick tod=420 -> peak 1 one cycle later; load 600 -> peak 0; mode=10 -> peak 1.
REQ-038 reset asserted mid-ARMING and mid-minute -> all outputs 0 asynchronously; release -> full DEB_ON latency re-applies.
